// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: icache request/response plus decoder/datapath handshake.
// master = fetch_unit view, slave = icache/decoder/datapath view.
interface fetch_unit_if;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] imemaddr;
    logic [31:0] ins;
    logic        ins_valid;
    logic [31:0] npc;
    logic        ins_ready;
    logic [1:0]  pcSel;
    logic [31:0] jr_addr;
    logic        halt;
    logic        halted;

    modport master (
        input  ihit, imemload, ins_ready, pcSel, jr_addr, halt,
        output iREN, imemaddr, ins, ins_valid, npc, halted
    );

    modport slave (
        output ihit, imemload, ins_ready, pcSel, jr_addr, halt,
        input  iREN, imemaddr, ins, ins_valid, npc, halted
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, reads the icache, holds ins for the decoder.
// Optional FETCH_PREFETCH_EN adds a one-entry sequential prefetch buffer.
module fetch_unit #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
    input  logic          CLK,
    input  logic          nRST,
    fetch_unit_if.master  bus
);
    localparam logic [1:0] PC_NPC  = 2'd0;
    localparam logic [1:0] PC_BR   = 2'd1;
    localparam logic [1:0] PC_JUMP = 2'd2;
    localparam logic [1:0] PC_JR   = 2'd3;

    typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_HOLD, ST_HALTED} state_t;

    state_t      r_state, w_state_nxt;
    logic [31:0] r_pc, r_ins, r_npc;
    logic [31:0] w_target, w_br_off;
    logic        w_pf_req, w_pf_hit, w_seq;
    logic [31:0] w_seq_word;

    assign w_br_off = {{14{r_ins[15]}}, r_ins[15:0], 2'b00};

    // Redirect target for the held instruction.
    always_comb begin
        w_target = r_npc;
        case (bus.pcSel)
            PC_NPC:  w_target = r_npc;
            PC_BR:   w_target = r_npc + w_br_off;
            PC_JUMP: w_target = {r_npc[31:28], r_ins[25:0], 2'b00};
            PC_JR:   w_target = bus.jr_addr & 32'hFFFF_FFFC;
            default: w_target = r_npc;
        endcase
    end

`ifdef FETCH_PREFETCH_EN
    logic [31:0] r_pbuf;
    logic        r_pbuf_valid;

    assign w_pf_req   = (r_state == ST_HOLD) && !r_pbuf_valid;
    assign w_pf_hit   = w_pf_req && bus.ihit;
    // A sequential retire stays in HOLD when the next word is buffered or arriving now.
    assign w_seq      = bus.ins_ready && !bus.halt && (bus.pcSel == PC_NPC)
                        && (r_pbuf_valid || w_pf_hit);
    assign w_seq_word = r_pbuf_valid ? r_pbuf : bus.imemload;

    // Prefetch buffer: filled by a HOLD-state hit, emptied by any retire.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_pbuf       <= 32'h0000_0000;
            r_pbuf_valid <= 1'b0;
        end else if (r_state == ST_HOLD && bus.ins_ready) begin
            r_pbuf_valid <= 1'b0;
        end else if (w_pf_hit) begin
            r_pbuf       <= bus.imemload;
            r_pbuf_valid <= 1'b1;
        end else begin
            r_pbuf_valid <= r_pbuf_valid;
        end
    end
`else
    assign w_pf_req   = 1'b0;
    assign w_pf_hit   = 1'b0;
    assign w_seq      = 1'b0;
    assign w_seq_word = 32'h0000_0000;
`endif

    // State register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and output decode.
    always_comb begin
        w_state_nxt   = r_state;
        bus.iREN      = 1'b0;
        bus.imemaddr  = r_pc & 32'hFFFF_FFFC;
        bus.ins_valid = 1'b0;
        bus.halted    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                bus.iREN    = 1'b1;
                w_state_nxt = bus.ihit ? ST_HOLD : ST_FETCH;
            end
            ST_HOLD: begin
                bus.ins_valid = 1'b1;
                bus.iREN      = w_pf_req;
                bus.imemaddr  = w_pf_req ? r_npc : (r_pc & 32'hFFFF_FFFC);
                if (!bus.ins_ready) begin
                    w_state_nxt = ST_HOLD;
                end else if (bus.halt) begin
                    w_state_nxt = ST_HALTED;
                end else if (w_seq) begin
                    w_state_nxt = ST_HOLD;
                end else begin
                    w_state_nxt = ST_FETCH;
                end
            end
            ST_HALTED: begin
                bus.halted  = 1'b1;
                w_state_nxt = ST_HALTED;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // PC, held instruction and link address.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_pc  <= PC_INIT;
            r_ins <= 32'h0000_0000;
            r_npc <= 32'h0000_0000;
        end else if (r_state == ST_FETCH && bus.ihit) begin
            r_ins <= bus.imemload;
            r_npc <= r_pc + 32'd4;
        end else if (r_state == ST_HOLD && bus.ins_ready && !bus.halt) begin
            if (w_seq) begin
                r_ins <= w_seq_word;
                r_npc <= r_npc + 32'd4;
                r_pc  <= r_npc;
            end else begin
                r_pc  <= w_target;
            end
        end else begin
            r_pc <= r_pc;
        end
    end

    assign bus.ins = r_ins;
    assign bus.npc = r_npc;
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage directly upstream of the decoder. It owns the program counter and issues instruction reads to the instruction cache. It holds each fetched word stable for the decoder until the datapath retires it, then computes the next PC from the decoder's `pcSel` (sequential, branch, jump, jump-register). It also latches `halt` into a terminal halted state.

## Interface
- `PC_INIT`, default 32'h0000_0000: PC value loaded on reset.

- `CLK`  in  1  system clock, rising edge.
- `nRST`  in  1  asynchronous active-low reset.
- `ihit`  in  1  icache has returned `imemload` for `imemaddr` this cycle; ignored while `iREN`=0.
- `imemload`  in  32  instruction word from icache.
- `iREN`  out  1  instruction read request; level, held until `ihit`.
- `imemaddr`  out  32  word address of the request; bits [1:0] always 0.
- `ins`  out  32  held instruction to decoder.
- `ins_valid`  out  1  `ins`/`npc` valid.
- `npc`  out  32  address of held `ins` + 4; used for `JAL` link and branch base.
- `ins_ready`  in  1  datapath retires held `ins` this cycle; it also asserts the decoder's data access is complete.
- `pcSel`  in  2 (pcMux)  next-PC select: `PC_NPC`, `PC_BR`, `PC_JUMP`, `PC_JR`.
- `jr_addr`  in  32  register value for `PC_JR` (rdat1).
- `halt`  in  1  decoder flags held `ins` as `HALT`.
- `halted`  out  1  halted state reached.

## Operation
- States: `IDLE`, `FETCH`, `HOLD`, `HALTED`. Reset: state=`IDLE`, pc=`PC_INIT`, ins=0, npc=0, prefetch buffer empty.
- `IDLE`: `iREN`=0. Goes to `FETCH` unconditionally on the next edge.
- `FETCH`: `iREN`=1, `imemaddr`=pc.
  - On `ihit`: ins<=`imemload`, npc<=pc+4, go to `HOLD`.
  - `ins_ready` is ignored in this state.
- `HOLD`: `ins_valid`=1; `ins` and `npc` stay stable until `ins_ready`.
  - On `ins_ready` with `halt`: go to `HALTED`. `pcSel` is don't-care and pc is unchanged.
  - On `ins_ready` without `halt`: pc<=target, go to `FETCH`.
  - Targets:
    - `PC_NPC`: npc.
    - `PC_BR`: npc + (sext(ins[15:0])<<2).
    - `PC_JUMP`: {npc[31:28], ins[25:0], 2'b00}.
    - `PC_JR`: {jr_addr[31:2], 2'b00}.
  - All additions are 32-bit modulo 2^32; wrap from 32'hFFFF_FFFC to 0 is legal.
- `HALTED`: terminal until `nRST`. `halted`=1, `iREN`=0, `ins_valid`=0.
- Outputs while `nRST` is low: `iREN`=0, `ins_valid`=0, `halted`=0, `imemaddr`=`PC_INIT`, `ins`=0, `npc`=0.

## Timing
- `ihit` in cycle N: `ins_valid`=1 in cycle N+1.
- `ins_ready` in cycle M: `iREN`=1 with the new `imemaddr` in cycle M+1.
- Base throughput is one instruction per 2 cycles plus icache latency.
- `ins_ready` and redirect are sampled only in `HOLD`.
- `ihit` is sampled only when `iREN`=1.
- `nRST` asserted mid-fetch or mid-hold: the in-flight request is abandoned and the prefetch buffer is cleared. Operation restarts from `PC_INIT` through `IDLE`.

## Configuration
- `FETCH_PREFETCH_EN` defined adds a one-entry sequential prefetch buffer (pbuf):
  - In `HOLD` with pbuf empty: `iREN`=1, `imemaddr`=npc. `ihit` captures `imemload` into pbuf.
  - On `ins_ready` with `PC_NPC` and pbuf full: ins<=pbuf, npc<=npc+4, pc<=npc. Stay in `HOLD` and clear pbuf.
  - If the prefetch `ihit` coincides with `ins_ready`+`PC_NPC`: `imemload` is forwarded directly into `ins`, and the state stays `HOLD`.
  - On a redirect (`PC_BR`, `PC_JUMP`, `PC_JR`) or `halt`: pbuf and any coincident `ihit` are discarded, and the non-prefetch behaviour applies.
  - Sequential code then sustains 1 instruction/cycle on back-to-back hits.
- `FETCH_PREFETCH_EN` undefined: no pbuf, and `iREN`=0 in `HOLD`.

## Test plan
- Reset and first fetch:
  - `PC_INIT`=0; release `nRST`. Required: cycle 0 has `iREN`=0.
  - Cycle 1 has `iREN`=1, `imemaddr`=0.
  - Then `ihit` with `imemload`=32'h2001_0005 (addi). Required next cycle: `ins_valid`=1, `ins`=32'h2001_0005, `npc`=4.
- Backward branch:
  - Held `ins` at pc 0x40 with ins[15:0]=16'hFFFE, `pcSel`=`PC_BR`, `ins_ready`=1.
  - Required next cycle: `imemaddr`=0x3C.
- Jump and JR:
  - `J` with ins[25:0]=26'h0000010 at npc 0x1000_0004 -> `imemaddr`=0x1000_0040.
  - `PC_JR` with `jr_addr`=0x123 -> `imemaddr`=0x120.
- Halt:
  - `ins_ready`+`halt` in `HOLD`. Required: `halted`=1 and `iREN`=0 on every subsequent cycle, regardless of `ihit`/`ins_ready`.
  - Then pulse `nRST`. Required: refetch from `PC_INIT`.
- Stall and reset:
  - Hold `ins_ready`=0 for 5 cycles. Required: `ins`/`npc` stable throughout.
  - Assert `nRST` mid-`FETCH`. Required: all outputs at their reset values immediately (asynchronous).
- Prefetch (`FETCH_PREFETCH_EN`):
  - Sequential run with `ihit` every cycle. Required: `ins_valid` continuously 1, `npc` incrementing by 4 per retire.
  - Redirect with pbuf full. Required: next `imemaddr` equals the target, not the pbuf address.
